// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multiply/divide unit.
// Holds the default operand width, the operation encoding and the
// sequencer state encoding, plus small decode helpers for the op field.
package alu_pkg;

  localparam int unsigned BITS_DEFAULT = 32;

  // Operation encoding as presented on the op input.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  // Divide ops have the upper encoding bit set.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // Signed ops have the lower encoding bit set.
  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle of the multiply/divide unit.
//   start, op, a, b     : operation request (sampled in IDLE)
//   mthi, mtlo, wdata   : direct HI/LO writes (honoured in IDLE)
//   busy, done, hi, lo  : status and the architectural HI/LO registers
// master = requester side, slave = the unit.
interface mult_div_unit_if
  import alu_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) ();

  logic            start;
  logic [1:0]      op;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            mthi;
  logic            mtlo;
  logic [BITS-1:0] wdata;
  logic            busy;
  logic            done;
  logic [BITS-1:0] hi;
  logic [BITS-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_adder.sv
// FullAdder: WIDTH-bit ripple adder with carry in/out.
//   a, b     : addends
//   carryIn  : carry into bit 0
//   sum      : WIDTH-bit sum
//   carryOut : carry out of the top bit
// Subtraction is done by the caller feeding ~b with carryIn = 1, in which
// case carryOut = 1 means a >= b (no borrow).
module FullAdder #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  localparam int unsigned EW = WIDTH + 1;

  assign {carryOut, sum} = EW'(a) + EW'(b) + EW'(carryIn);

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : start/op/a/b request, mthi/mtlo/wdata direct writes,
//                  busy/done status, hi/lo result registers
// One operation at a time: IDLE -> PREP (magnitudes and signs) ->
// RUN (BITS shift-add or restoring-divide steps) -> FIX (sign correction,
// HI/LO write on the exit edge) -> IDLE with a one-cycle done pulse.
module mult_div_unit
  import alu_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input logic             clock,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(BITS + 1);
  localparam int unsigned AW    = BITS + 1;
  localparam int unsigned PW    = 2 * BITS;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [BITS-1:0] acc_hi_q, acc_hi_d; // partial product high / remainder
  logic [BITS-1:0] acc_lo_q, acc_lo_d; // multiplier-product low / dividend-quotient
  logic [BITS-1:0] hi_q, hi_d;
  logic [BITS-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;       // product / quotient negative
  logic            rem_neg_q, rem_neg_d;
  logic            div0_q, div0_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            is_div;
  logic            a_neg, b_neg;
  logic [BITS-1:0] mag_a, mag_b;
  logic            run_last;
  logic [AW-1:0]   shift_rem;
  logic [AW-1:0]   add_a, add_b, add_sum;
  logic            add_ci, add_co;
  logic [AW-1:0]   mul_step;
  logic [PW-1:0]   prod, prod_fix;
  logic [BITS-1:0] quo_fix, rem_fix;

  // Operand decode used in PREP.
  assign is_div   = op_is_div(op_q);
  assign a_neg    = op_is_signed(op_q) & a_q[BITS-1];
  assign b_neg    = op_is_signed(op_q) & b_q[BITS-1];
  assign mag_a    = a_neg ? (~a_q + BITS'(1)) : a_q;
  assign mag_b    = b_neg ? (~b_q + BITS'(1)) : b_q;
  assign run_last = (cnt_q == CNT_W'(BITS - 1));

  // Shared step adder: add multiplicand, or trial-subtract divisor from the
  // remainder shifted left with the next dividend bit.
  assign shift_rem = {acc_hi_q, acc_lo_q[BITS-1]};
  assign add_a     = is_div ? shift_rem : {1'b0, acc_hi_q};
  assign add_b     = is_div ? ~{1'b0, mcand_q} : {1'b0, mcand_q};
  assign add_ci    = is_div;

  FullAdder #(.WIDTH(AW)) u_step (
    .a        (add_a),
    .b        (add_b),
    .carryIn  (add_ci),
    .sum      (add_sum),
    .carryOut (add_co)
  );

  // Multiply step keeps the sum only when the current multiplier bit is set.
  assign mul_step = acc_lo_q[0] ? add_sum : {1'b0, acc_hi_q};

  // Sign correction of the magnitude results.
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? (~prod + PW'(1)) : prod;
  assign quo_fix  = neg_q ? (~acc_lo_q + BITS'(1)) : acc_lo_q;
  assign rem_fix  = rem_neg_q ? (~acc_hi_q + BITS'(1)) : acc_hi_q;

  // State register and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_PREP;
      ST_PREP: state_d = ST_RUN;
      ST_RUN:  if (run_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs: busy tracks the upcoming state, done marks the FIX exit.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FIX);
  end

  // Datapath next values.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start) begin
          op_d = op_e'(bus.op);
          a_d  = bus.a;
          b_d  = bus.b;
        end
      end
      ST_PREP: begin
        cnt_d    = '0;
        acc_hi_d = '0;
        neg_d    = a_neg ^ b_neg;
        if (is_div) begin
          acc_lo_d  = mag_a;
          mcand_d   = mag_b;
          rem_neg_d = a_neg;
          div0_d    = (b_q == '0);
        end else begin
          acc_lo_d  = mag_b;
          mcand_d   = mag_a;
          rem_neg_d = 1'b0;
          div0_d    = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div) begin
          // Restore (keep the shifted remainder) when the trial borrowed.
          acc_hi_d = add_co ? add_sum[BITS-1:0] : shift_rem[BITS-1:0];
          acc_lo_d = {acc_lo_q[BITS-2:0], add_co};
        end else begin
          acc_hi_d = mul_step[AW-1:1];
          acc_lo_d = {mul_step[0], acc_lo_q[BITS-1:1]};
        end
      end
      ST_FIX: begin
        if (div0_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else if (is_div) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q      <= OP_MULTU;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit (BITS = 32).
// Expected results come from directed constants and from an arithmetic
// reference model using native multiply, divide and modulo.
module tb_mult_div_unit;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mult_div_unit_if #(.BITS(W)) bus ();

  mult_div_unit #(.BITS(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Directed vectors: op, a, b, expected hi, expected lo.
  logic [1:0]  d_op [9] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
  logic [31:0] d_a  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100,
                            32'd5, 32'h80000000, 32'd7, 32'hFFFFFFF8};
  logic [31:0] d_b  [9] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd7,
                            32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] d_hi [9] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2,
                            32'd5, 32'd0, 32'd7, 32'hFFFFFFF8};
  logic [31:0] d_lo [9] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFD, 32'd14,
                            32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

  // Reference model from the architectural rules.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = a; hi = 32'd0; end
        else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = 32'(q);
          hi = 32'(r);
        end
      end
    endcase
  endfunction

  // Drives one operation and reports what was seen up to the done pulse.
  // done_cyc counts falling edges after the start edge (0 = never seen).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int busy_cnt, output int done_cyc, output bit leaked);
    logic [31:0] hi0, lo0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    hi0       = bus.hi;
    lo0       = bus.lo;
    busy_cnt  = 0;
    done_cyc  = 0;
    leaked    = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      if (bus.busy) begin
        busy_cnt++;
        if (bus.hi !== hi0 || bus.lo !== lo0) leaked = 1'b1;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    hi = bus.hi;
    lo = bus.lo;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic [31:0] hi, lo;
    int bc, dc;
    bit lk;
    for (int i = 0; i < 9; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], hi, lo, bc, dc, lk);
      checks++;
      if (hi !== d_hi[i] || lo !== d_lo[i]) begin
        failures++;
        $display("FAIL directed_%0d result: hi=%h lo=%h, required hi=%h lo=%h",
                 i, hi, lo, d_hi[i], d_lo[i]);
      end
      checks++;
      if (bc !== 34 || dc !== 35) begin
        failures++;
        $display("FAIL directed_%0d latency: busy=%0d done_at=%0d, required 34 and 35", i, bc, dc);
      end
      checks++;
      if (lk !== 1'b0) begin
        failures++;
        $display("FAIL directed_%0d hold: hi/lo changed while busy, required stable", i);
      end
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL directed_%0d pulse: done=%b busy=%b after pulse, required 0 0",
                 i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, ehi, elo, a, b;
    logic [1:0]  op;
    int bc, dc;
    bit lk;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      model(op, a, b, ehi, elo);
      run_op(op, a, b, hi, lo, bc, dc, lk);
      checks++;
      if (hi !== ehi || lo !== elo || dc !== 35) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h done_at=%0d, required hi=%h lo=%h done_at=35",
                 i, op, a, b, hi, lo, dc, ehi, elo);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] ehi, elo;
    int dones;
    model(2'b01, 32'hFFFF1234, 32'd99, ehi, elo);
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF1234; bus.b = 32'd99;
    dones = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clock);
      bus.start = (cyc == 12);
      bus.op    = 2'b10;
      bus.a     = 32'd1000;
      bus.b     = 32'd3;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL start_while_busy done_count: got %0d, required 1", dones);
    end
    checks++;
    if (bus.hi !== ehi || bus.lo !== elo) begin
      failures++;
      $display("FAIL start_while_busy result: hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, ehi, elo);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] hi, lo;
    int bc, dc, dones;
    bit lk;
    bit nonzero;
    @(negedge clock);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(negedge clock);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'd3;
    // falling edge k after the start edge: k=1 PREP, k=11 RUN cycle 10
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_run state: busy=%b done=%b hi=%h lo=%h, required all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    reset = 1'b0;
    dones = 0;
    nonzero = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.done) dones++;
      if (bus.busy || bus.hi !== 32'd0 || bus.lo !== 32'd0) nonzero = 1'b1;
    end
    checks++;
    if (dones !== 0 || nonzero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run aftermath: dones=%0d activity=%b, required 0 and 0", dones, nonzero);
    end
    run_op(2'b00, 32'd6, 32'd7, hi, lo, bc, dc, lk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd42 || bc !== 34 || dc !== 35) begin
      failures++;
      $display("FAIL reset_mid_run next_op: hi=%h lo=%h busy=%0d done_at=%0d, required 0 42 34 35",
               hi, lo, bc, dc);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    int dc;
    @(negedge clock);
    lo_before = bus.lo;
    bus.mthi = 1'b1; bus.wdata = 32'h00001234;
    @(negedge clock);
    bus.mthi = 1'b0;
    checks++;
    if (bus.hi !== 32'h00001234 || bus.lo !== lo_before) begin
      failures++;
      $display("FAIL mthi_idle: hi=%h lo=%h, required hi=00001234 lo=%h", bus.hi, bus.lo, lo_before);
    end
    bus.mtlo = 1'b1; bus.wdata = 32'h00009ABC;
    @(negedge clock);
    bus.mtlo = 1'b0;
    checks++;
    if (bus.lo !== 32'h00009ABC || bus.hi !== 32'h00001234) begin
      failures++;
      $display("FAIL mtlo_idle: hi=%h lo=%h, required hi=00001234 lo=00009abc", bus.hi, bus.lo);
    end
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
    dc = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.mtlo  = (cyc == 5);
      bus.mthi  = (cyc == 5);
      bus.wdata = 32'h00005678;
      if (cyc == 6) begin
        checks++;
        if (bus.lo !== 32'h00009ABC || bus.hi !== 32'h00001234) begin
          failures++;
          $display("FAIL mtlo_busy: hi=%h lo=%h, required hi=00001234 lo=00009abc", bus.hi, bus.lo);
        end
      end
      if (bus.done) begin
        dc = cyc;
        break;
      end
    end
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checks++;
    if (dc !== 35 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      failures++;
      $display("FAIL mtlo_busy result: done_at=%0d hi=%h lo=%h, required 35 2 14", dc, bus.hi, bus.lo);
    end
  endtask

  task automatic test_coincident();
    int dc;
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7;
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000DEAD;
    @(negedge clock);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checks++;
    if (bus.hi !== 32'h0000DEAD || bus.lo !== 32'h0000DEAD || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL coincident_write: hi=%h lo=%h busy=%b, required dead dead 1", bus.hi, bus.lo, bus.busy);
    end
    dc = 0;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge clock);
      if (bus.done) begin
        dc = cyc;
        break;
      end
    end
    checks++;
    if (dc !== 35 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      failures++;
      $display("FAIL coincident_result: done_at=%0d hi=%h lo=%h, required 35 0 42", dc, bus.hi, bus.lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid_run();
    test_mthi_mtlo();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
